mp_add_sequencer: RTL

Multi-precision add/subtract sequencer that drives the 16-bit alu_adder one limb per cycle, least-significant limb first. It chains the adder's carry between limbs, collects the 16-bit sums into a WORDS*16-bit result and folds the per-limb results into whole-word flags. It sits between the operand source (valid/ready) and the result consumer (valid/ready) and owns the only alu_adder instance on this path.

---
 rtl/mp_add_sequencer_pkg.sv | 26 ++
 rtl/mp_add_sequencer_if.sv | 39 +++
 rtl/mp_add_sequencer_adder.sv | 20 ++
 rtl/mp_add_sequencer.sv | 116 +++++++++++
 4 files changed

// File: rtl/mp_add_sequencer_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// mp_add_sequencer_pkg : shared limb width, FSM encoding and flag record
// Revision: 1.0
// ============================================================================
package mp_add_sequencer_pkg;

    localparam int LIMB_W = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef logic [LIMB_W-1:0] limb_t;

    typedef struct packed {
        logic cout;
        logic sign;
        logic zero;
        logic parity;
        logic overflow;
    } flags_t;

endpackage
`default_nettype wire

// File: rtl/mp_add_sequencer_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// mp_add_sequencer_if : operand request and result handshake bundle
// Revision: 1.0
// ============================================================================
interface mp_add_sequencer_if
    import mp_add_sequencer_pkg::*;
#(
    parameter int WORDS = 4
);
    logic                      in_valid;
    logic                      in_ready;
    logic [LIMB_W*WORDS-1:0]   in_a;
    logic [LIMB_W*WORDS-1:0]   in_b;
    logic                      in_cin;
    logic                      in_sub;
    logic                      out_valid;
    logic                      out_ready;
    logic [LIMB_W*WORDS-1:0]   out_s;
    logic                      out_cout;
    logic                      out_sign;
    logic                      out_zero;
    logic                      out_parity;
    logic                      out_overflow;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_s, out_cout, out_sign,
               out_zero, out_parity, out_overflow
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_s, out_cout, out_sign,
               out_zero, out_parity, out_overflow
    );
endinterface
`default_nettype wire

// File: rtl/mp_add_sequencer_adder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// alu_adder : 16-bit ripple adder with carry-out and signed overflow
// Revision: 1.0
// ============================================================================
module alu_adder
    import mp_add_sequencer_pkg::*;
(
    input  wire limb_t a,
    input  wire limb_t b,
    input  wire logic  cin,
    output limb_t      s,
    output logic       cout,
    output logic       overflow
);
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{LIMB_W{1'b0}}, cin};
    assign overflow  = (a[LIMB_W-1] == b[LIMB_W-1]) && (s[LIMB_W-1] != a[LIMB_W-1]);
endmodule
`default_nettype wire

// File: rtl/mp_add_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// mp_add_sequencer : limb-serial multi-precision add/subtract, LS limb first
// Revision: 1.0
// ============================================================================
module mp_add_sequencer
    import mp_add_sequencer_pkg::*;
#(
    parameter int WORDS = 4
)(
    input  wire logic           clk,
    input  wire logic           rst_n,
    mp_add_sequencer_if.slave   bus
);
    localparam int IDX_W = $clog2(WORDS);

    logic [1:0]                    r_state;
    logic [1:0]                    w_next;
    logic [IDX_W-1:0]              r_idx;
    logic [WORDS-1:0][LIMB_W-1:0]  r_a;
    logic [WORDS-1:0][LIMB_W-1:0]  r_b;
    logic [WORDS-1:0][LIMB_W-1:0]  r_res;
    logic                          r_carry;
    logic                          r_zero_acc;
    logic                          r_par_acc;
    flags_t                        r_flags;

    limb_t                         w_s;
    logic                          w_cout;
    logic                          w_ovf;
    logic                          w_last;

    alu_adder u_adder (
        .a        (r_a[r_idx]),
        .b        (r_b[r_idx]),
        .cin      (r_carry),
        .s        (w_s),
        .cout     (w_cout),
        .overflow (w_ovf)
    );

    assign w_last = (r_idx == IDX_W'(WORDS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.in_valid)                  w_next = ST_RUN;
            ST_RUN:  if (w_last)                        w_next = ST_DONE;
            ST_DONE: if (bus.out_ready)                 w_next = ST_IDLE;
            default:                                    w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (r_state == ST_IDLE);
        bus.out_valid = (r_state == ST_DONE);
    end

    // Subtraction is A + ~B + 1: B is inverted once at capture, the +1 rides in on the carry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_res      <= '0;
            r_carry    <= 1'b0;
            r_zero_acc <= 1'b0;
            r_par_acc  <= 1'b0;
            r_flags    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_a        <= bus.in_a;
                        r_b        <= bus.in_sub ? ~bus.in_b : bus.in_b;
                        r_carry    <= bus.in_sub | bus.in_cin;
                        r_idx      <= '0;
                        r_zero_acc <= 1'b1;
                        r_par_acc  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_res[r_idx] <= w_s;
                    r_carry      <= w_cout;
                    r_zero_acc   <= r_zero_acc & (w_s == '0);
                    r_par_acc    <= r_par_acc ^ (^w_s);
                    if (w_last) begin
                        r_flags.cout     <= w_cout;
                        r_flags.sign     <= w_s[LIMB_W-1];
                        r_flags.overflow <= w_ovf;
                        r_flags.zero     <= r_zero_acc & (w_s == '0);
                        r_flags.parity   <= r_par_acc ^ (^w_s);
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out_s        = r_res;
    assign bus.out_cout     = r_flags.cout;
    assign bus.out_sign     = r_flags.sign;
    assign bus.out_zero     = r_flags.zero;
    assign bus.out_parity   = r_flags.parity;
    assign bus.out_overflow = r_flags.overflow;

endmodule
`default_nettype wire
